bcd_updown_timer: RTL and testbench

//  Parametrised seconds-style timer; counts natively in packed BCD, so no binary-to-decimal divide is needed.

---
 rtl/bcd_updown_timer_pkg.sv | 15 +
 rtl/bcd_updown_timer_bcd_digit.sv | 51 +++++
 rtl/bcd_updown_timer.sv | 71 +++++++
 tb/tb_bcd_updown_timer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_updown_timer_pkg.sv
// Shared definitions for the BCD up/down timer: digit width, digit ceiling,
// direction encodings and the load-value digit clamp.
package bcd_updown_timer_pkg;

  localparam int         BCD_W    = 4;
  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic       DIR_UP   = 1'b1;
  localparam logic       DIR_DOWN = 1'b0;

  // Digits above 9 cannot be represented in BCD; saturate them to 9.
  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_updown_timer_bcd_digit.sv
// One packed-BCD digit of the timer: holds 0..9, steps up or down when
// step_in is high and signals a carry/borrow to the next digit.
module bcd_digit
  import bcd_updown_timer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             step_in,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [BCD_W-1:0] ld_val,
  output logic [BCD_W-1:0] digit,
  output logic             carry_out
);

  logic [BCD_W-1:0] d_q;
  logic [BCD_W-1:0] d_next;
  logic             at_limit;

  // The digit rolls over (and passes the step on) at 9 going up or 0 going down.
  assign at_limit  = (up == DIR_UP) ? (d_q == BCD_MAX) : (d_q == '0);
  assign carry_out = step_in & at_limit;
  assign digit     = d_q;

  always_comb begin
    d_next = d_q;
    if (clr) begin
      d_next = '0;
    end else if (load) begin
      d_next = bcd_clamp(ld_val);
    end else if (step_in) begin
      if (at_limit) begin
        d_next = (up == DIR_UP) ? '0 : BCD_MAX;
      end else if (up == DIR_UP) begin
        d_next = d_q + 4'd1;
      end else begin
        d_next = d_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_q <= '0;
    end else begin
      d_q <= d_next;
    end
  end

endmodule

// File: rtl/bcd_updown_timer.sv
// Prescaled packed-BCD up/down timer with pause, clear and parallel load.
// The prescaler decides the step edge; a ripple chain of bcd_digit does the counting.
module bcd_updown_timer
  import bcd_updown_timer_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 100_000_000,
  parameter int PRE_W    = 27
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clr,
  input  logic                  load,
  input  logic [BCD_W*DIGITS-1:0] load_val,
  output logic [BCD_W*DIGITS-1:0] bcd,
  output logic                  tick,
  output logic                  wrap
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] pre;
  logic             step;
  logic [DIGITS:0]  carry;

  // clr and load override a step that would otherwise land on this edge.
  assign step     = en & ~clr & ~load & (pre == PRE_LAST);
  assign carry[0] = step;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre <= '0;
    end else if (clr || load) begin
      pre <= '0;
    end else if (en) begin
      if (pre == PRE_LAST) begin
        pre <= '0;
      end else begin
        pre <= pre + PRE_W'(1);
      end
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk       (clk),
      .rst       (rst),
      .step_in   (carry[g]),
      .up        (up),
      .clr       (clr),
      .load      (load),
      .ld_val    (load_val[g*BCD_W +: BCD_W]),
      .digit     (bcd[g*BCD_W +: BCD_W]),
      .carry_out (carry[g+1])
    );
  end

  // A carry out of the top digit only exists on a step, so wrap implies tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick <= 1'b0;
      wrap <= 1'b0;
    end else begin
      tick <= step;
      wrap <= carry[DIGITS];
    end
  end

endmodule

// File: tb/tb_bcd_updown_timer.sv
// Directed bench for bcd_updown_timer: a TICK_DIV=4 instance for the main
// behaviour and a TICK_DIV=1 instance for the step-every-cycle build.
module tb_bcd_updown_timer;

  logic        clk;
  logic        rst;
  logic        en, up, clr, load;
  logic [15:0] load_val;
  logic [15:0] bcd;
  logic        tick, wrap;

  logic        en1, up1, clr1, load1;
  logic [15:0] load_val1;
  logic [15:0] bcd1;
  logic        tick1, wrap1;

  int n_checks = 0;
  int n_errors = 0;

  bcd_updown_timer #(.DIGITS(4), .TICK_DIV(4), .PRE_W(3)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .bcd(bcd), .tick(tick), .wrap(wrap)
  );

  bcd_updown_timer #(.DIGITS(4), .TICK_DIV(1), .PRE_W(1)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .up(up1), .clr(clr1), .load(load1),
    .load_val(load_val1), .bcd(bcd1), .tick(tick1), .wrap(wrap1)
  );

  // clock/reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) cyc();
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0;
    en1 = 1'b0; up1 = 1'b1; clr1 = 1'b0; load1 = 1'b0; load_val1 = '0;

    // Reset state
    #3;
    chk("rst_bcd", bcd, 16'h0000);
    chk("rst_tick", {15'd0, tick}, 16'd0);
    chk("rst_wrap", {15'd0, wrap}, 16'd0);
    chk("rst_bcd1", bcd1, 16'h0000);
    cycles(2);

    // 1. first step on the 4th edge, then every 4 edges
    rst = 1'b1; en = 1'b1;
    cycles(3);
    chk("t1_no_tick_early", {15'd0, tick}, 16'd0);
    chk("t1_bcd_early", bcd, 16'h0000);
    cyc();
    chk("t1_first_tick", {15'd0, tick}, 16'd1);
    chk("t1_first_bcd", bcd, 16'h0001);
    for (int k = 5; k <= 40; k++) begin
      cyc();
      chk("t1_tick_cadence", {15'd0, tick}, (k % 4 == 0) ? 16'd1 : 16'd0);
    end
    chk("t1_bcd_40", bcd, 16'h0010);

    // 2. up wrap
    load = 1'b1; load_val = 16'h9998;
    cyc();
    chk("t2_load", bcd, 16'h9998);
    chk("t2_load_tick", {15'd0, tick}, 16'd0);
    load = 1'b0;
    cycles(4);
    chk("t2_9999", bcd, 16'h9999);
    chk("t2_9999_wrap", {15'd0, wrap}, 16'd0);
    cycles(4);
    chk("t2_wrap_bcd", bcd, 16'h0000);
    chk("t2_wrap_tick", {15'd0, tick}, 16'd1);
    chk("t2_wrap", {15'd0, wrap}, 16'd1);
    cyc();
    chk("t2_wrap_pulse", {15'd0, wrap}, 16'd0);

    // 3. down borrow and down wrap
    up = 1'b0; load = 1'b1; load_val = 16'h0100;
    cyc();
    load = 1'b0;
    cycles(4);
    chk("t3_borrow", bcd, 16'h0099);
    chk("t3_borrow_wrap", {15'd0, wrap}, 16'd0);
    load = 1'b1; load_val = 16'h0000;
    cyc();
    load = 1'b0;
    cycles(4);
    chk("t3_down_wrap_bcd", bcd, 16'h9999);
    chk("t3_down_wrap", {15'd0, wrap}, 16'd1);
    chk("t3_down_wrap_tick", {15'd0, tick}, 16'd1);

    // 4. pause keeps the partial period
    up = 1'b1; load = 1'b1; load_val = 16'h0000;
    cyc();
    load = 1'b0;
    cycles(2);
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("t4_pause_tick", {15'd0, tick}, 16'd0);
    end
    chk("t4_pause_bcd", bcd, 16'h0000);
    en = 1'b1;
    cyc();
    chk("t4_resume_1", {15'd0, tick}, 16'd0);
    cyc();
    chk("t4_resume_2", {15'd0, tick}, 16'd1);
    chk("t4_resume_bcd", bcd, 16'h0001);

    // 5. digit clamp, clr over load, load over step, mid-period direction, clr
    load = 1'b1; load_val = 16'hA3F0;
    cyc();
    chk("t5_clamp", bcd, 16'h9390);
    clr = 1'b1; load_val = 16'h1234;
    cyc();
    chk("t5_clr_over_load", bcd, 16'h0000);
    clr = 1'b0; load = 1'b0;
    cycles(3);
    load = 1'b1; load_val = 16'h0555;
    cyc();
    chk("t5_load_on_step", bcd, 16'h0555);
    chk("t5_load_on_step_tick", {15'd0, tick}, 16'd0);
    load = 1'b0;
    cycles(3);
    chk("t5_pre_reset_by_load", {15'd0, tick}, 16'd0);
    cyc();
    chk("t5_after_load_step", bcd, 16'h0556);
    cycles(2);
    up = 1'b0;
    cycles(2);
    chk("t5_dir_change_bcd", bcd, 16'h0555);
    chk("t5_dir_change_tick", {15'd0, tick}, 16'd1);
    cycles(2);
    clr = 1'b1;
    cyc();
    chk("t5_clr_bcd", bcd, 16'h0000);
    clr = 1'b0; up = 1'b1;
    cycles(3);
    chk("t5_clr_pre", {15'd0, tick}, 16'd0);
    cyc();
    chk("t5_clr_step", bcd, 16'h0001);

    // 6. asynchronous reset while tick/wrap are high
    up = 1'b0; load = 1'b1; load_val = 16'h0000;
    cyc();
    load = 1'b0;
    cycles(4);
    chk("t6_pre_rst_wrap", {15'd0, wrap}, 16'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_async_bcd", bcd, 16'h0000);
    chk("t6_async_tick", {15'd0, tick}, 16'd0);
    chk("t6_async_wrap", {15'd0, wrap}, 16'd0);
    cycles(2);
    chk("t6_held_bcd", bcd, 16'h0000);

    // TICK_DIV=1 build: one step per enabled edge
    rst = 1'b1; up = 1'b1; en1 = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      chk("t6_div1_count", bcd1, 16'(k));
      chk("t6_div1_tick", {15'd0, tick1}, 16'd1);
    end
    load1 = 1'b1; load_val1 = 16'h0098;
    cyc();
    chk("t6_div1_load", bcd1, 16'h0098);
    load1 = 1'b0;
    cyc();
    chk("t6_div1_0099", bcd1, 16'h0099);
    cyc();
    chk("t6_div1_0100", bcd1, 16'h0100);
    cyc();
    chk("t6_div1_0101", bcd1, 16'h0101);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
